aclk_time_counter: RTL and testbench
====================================

// Module: aclk_time_counter
// PURPOSE
//  Alarm-clock timebase and current-time keeper; sits directly upstream of the 4-digit LCD driver.
//  Divides the system clock into one-second/one-minute ticks and maintains a 24-hour HH:MM time.
//  Time is held as four BCD digits and drives current_time_* on the display/alarm-compare stage.
//  Supports a validated parallel time load and a fast_watch mode (1 minute advances per second).
// PARAMETERS
//  CLK_PER_SEC  256  clock cycles per second; must be >=2; sim benches use 4
//  SEC_PER_MIN  60   seconds per minute; must be >=2; sim benches use 3
// PORTS
//  clock                 in   1  system clock, all state on rising edge
//  reset                 in   1  synchronous, active-high; overrides every other input
//  fast_watch            in   1  1: minute advances on every one_second tick
//  load_new_c            in   1  1: load new_current_time_* at this edge (level-sampled)
//  new_current_time_ms_hr in  4  BCD hours tens, legal 0-2
//  new_current_time_ls_hr in  4  BCD hours units, legal 0-9 (0-3 when ms_hr==2)
//  new_current_time_ms_min in 4  BCD minutes tens, legal 0-5
//  new_current_time_ls_min in 4  BCD minutes units, legal 0-9
//  current_time_ms_hr    out  4  registered BCD hours tens
//  current_time_ls_hr    out  4  registered BCD hours units
//  current_time_ms_min   out  4  registered BCD minutes tens
//  current_time_ls_min   out  4  registered BCD minutes units
//  one_second            out  1  registered 1-cycle pulse per second
//  one_minute            out  1  registered 1-cycle pulse coincident with each minute advance
//  load_error            out  1  registered 1-cycle pulse: rejected load
// BEHAVIOUR
//  Reset: all time digits 0 (00:00), prescaler 0, seconds 0, one_second/one_minute/load_error 0.
//  Prescaler: counts 0..CLK_PER_SEC-1, wraps; sec_tc = (prescaler==CLK_PER_SEC-1).
//  one_second is 1 in the cycle after each sec_tc edge; the first pulse comes CLK_PER_SEC cycles after reset release.
//  Seconds counter: 0..SEC_PER_MIN-1, advances on sec_tc; min_tc = sec_tc & (seconds==SEC_PER_MIN-1).
//  fast_watch=1: min_tc = sec_tc; seconds counter held at 0.
//  Minute advance on min_tc edge; new time and one_minute are visible together in the next cycle.
//  Carry chain: ls_min 9->0 carries; ms_min 5->0 carries; ls_hr 9->0 carries to ms_hr.
//  Hour wrap: 23:59 -> 00:00 (ls_hr 3->0 and ms_hr 2->0 when ms_hr==2).
//  Load valid if all digits legal as above; at that edge time <= new_*.
//  A valid load also clears prescaler and seconds; no one_second/one_minute pulse results.
//  Load invalid: time, prescaler and seconds unchanged; load_error=1 for the next cycle.
//  Precedence per edge: reset > load_new_c > min_tc advance; a load coinciding with min_tc suppresses the advance and one_minute.
//  Held load_new_c reloads every cycle (prescaler stays 0); an invalid held load pulses load_error each cycle.
//  Reset asserted mid-count or mid-load returns to the reset state at that edge, with no pulses.
//  Outputs never show a non-BCD or out-of-range value.
// STRUCTURE
//  aclk_pkg: BCD digit typedef [3:0]; constants MAX_MS_HR=2, MAX_LS_HR_AT_20=3, MAX_MS_MIN=5, MAX_LS=9.
//  aclk_pkg also holds the function is_valid_time(ms_hr, ls_hr, ms_min, ls_min), shared with the alarm register.
//  Sub-module aclk_prescaler: clock/reset -> sec_tc, one_second; parameter CLK_PER_SEC.
//  Seconds counter, load check and BCD carry chain stay in this module.
// TESTING (CLK_PER_SEC=4, SEC_PER_MIN=3)
//  1 Reset, then run: all outputs 0 during reset; one_second at cycle 4, 8, ... after release; one_minute every 12 cycles; time 00:01 with the 1st.
//  2 Load 09:59 then one minute -> 10:00; load 19:59 -> 20:00; load 23:59 -> 00:00 with one_minute=1.
//  3 Invalid loads 24:00, 19:60, 2A:00, 30:00: time unchanged; load_error pulses 1 cycle each; a valid 12:34 load -> 12:34 with load_error=0.
//  4 fast_watch=1 from 00:00 for 8 one_second ticks -> 00:08, with one_minute on every tick; clearing it restores the 12-cycle minute.
//  5 load_new_c (07:45) on the same edge as min_tc: time=07:45, no one_minute; next minute after 12 more cycles -> 07:46.
//  6 reset asserted mid-minute at 05:17 with a load pending: next cycle 00:00, prescaler restarts, no pulses, load ignored.

Source files
------------

// File: rtl/aclk_pkg.sv
`default_nettype none
// ============================================================================
// aclk_pkg : BCD digit type, digit limits and time-legality check for the
//            alarm-clock datapath.                              Rev 1.0
// ============================================================================
package aclk_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t MAX_MS_HR       = 4'd2;
   localparam bcd_t MAX_LS_HR_AT_20 = 4'd3;
   localparam bcd_t MAX_MS_MIN      = 4'd5;
   localparam bcd_t MAX_LS          = 4'd9;

   // Also used by the alarm register, so keep it free of any counter state.
   function automatic logic is_valid_time(input bcd_t ms_hr, input bcd_t ls_hr,
                                          input bcd_t ms_min, input bcd_t ls_min);
      logic ok;
      ok = (ms_hr <= MAX_MS_HR) && (ls_hr <= MAX_LS) &&
           (ms_min <= MAX_MS_MIN) && (ls_min <= MAX_LS);
      if (ms_hr == MAX_MS_HR && ls_hr > MAX_LS_HR_AT_20)
         ok = 1'b0;
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aclk_prescaler.sv
`default_nettype none
// ============================================================================
// aclk_prescaler : divides the system clock to a per-second terminal count
//                  and a registered one-cycle one_second pulse.   Rev 1.0
// ============================================================================
module aclk_prescaler #(
   parameter int unsigned CLK_PER_SEC = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic hold_i,
   output logic sec_tc_o,
   output logic one_second_o
);

   localparam int unsigned CW = $clog2(CLK_PER_SEC);
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

   logic [CW-1:0] count_q, count_d;
   logic          one_second_q, one_second_d;

   assign sec_tc_o = (count_q == LAST);

   // A pending load (valid or not) owns this edge, so no second is counted.
   always_comb begin
      count_d      = count_q;
      one_second_d = 1'b0;
      if (clear_i) begin
         count_d = '0;
      end else if (!hold_i) begin
         count_d      = sec_tc_o ? '0 : count_q + 1'b1;
         one_second_d = sec_tc_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q      <= '0;
         one_second_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         one_second_q <= one_second_d;
      end
   end

   assign one_second_o = one_second_q;

endmodule
`default_nettype wire

// File: rtl/aclk_time_counter.sv
`default_nettype none
// ============================================================================
// aclk_time_counter : seconds/minutes timebase and 24-hour BCD HH:MM keeper
//                     with validated parallel load and fast_watch.  Rev 1.0
// ============================================================================
module aclk_time_counter
   import aclk_pkg::*;
#(
   parameter int unsigned CLK_PER_SEC = 256,
   parameter int unsigned SEC_PER_MIN = 60
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       fast_watch,
   input  logic       load_new_c,
   input  logic [3:0] new_current_time_ms_hr,
   input  logic [3:0] new_current_time_ls_hr,
   input  logic [3:0] new_current_time_ms_min,
   input  logic [3:0] new_current_time_ls_min,
   output logic [3:0] current_time_ms_hr,
   output logic [3:0] current_time_ls_hr,
   output logic [3:0] current_time_ms_min,
   output logic [3:0] current_time_ls_min,
   output logic       one_second,
   output logic       one_minute,
   output logic       load_error
);

   localparam int unsigned SW = $clog2(SEC_PER_MIN);
   localparam logic [SW-1:0] SEC_LAST = SW'(SEC_PER_MIN - 1);

   logic          sec_tc, load_ok, min_tc;
   logic [SW-1:0] sec_q, sec_d;
   bcd_t          ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
   bcd_t          ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
   logic          one_minute_q, load_error_q;

   assign load_ok = load_new_c &&
                    is_valid_time(new_current_time_ms_hr, new_current_time_ls_hr,
                                  new_current_time_ms_min, new_current_time_ls_min);

   aclk_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_prescaler (
      .clk_i        (clock),
      .rst_i        (reset),
      .clear_i      (load_ok),
      .hold_i       (load_new_c),
      .sec_tc_o     (sec_tc),
      .one_second_o (one_second)
   );

   assign min_tc = sec_tc && !load_new_c && (fast_watch || sec_q == SEC_LAST);

   always_comb begin
      sec_d = sec_q;
      if (load_ok || fast_watch)
         sec_d = '0;
      else if (sec_tc && !load_new_c)
         sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + 1'b1;
   end

   always_comb begin
      ms_hr_d  = ms_hr_q;
      ls_hr_d  = ls_hr_q;
      ms_min_d = ms_min_q;
      ls_min_d = ls_min_q;
      if (load_ok) begin
         ms_hr_d  = new_current_time_ms_hr;
         ls_hr_d  = new_current_time_ls_hr;
         ms_min_d = new_current_time_ms_min;
         ls_min_d = new_current_time_ls_min;
      end else if (min_tc) begin
         // Ripple the carry up the digits; 23 wraps straight to 00.
         ls_min_d = (ls_min_q == MAX_LS) ? 4'd0 : ls_min_q + 4'd1;
         if (ls_min_q == MAX_LS) begin
            ms_min_d = (ms_min_q == MAX_MS_MIN) ? 4'd0 : ms_min_q + 4'd1;
            if (ms_min_q == MAX_MS_MIN) begin
               if (ms_hr_q == MAX_MS_HR && ls_hr_q == MAX_LS_HR_AT_20) begin
                  ms_hr_d = 4'd0;
                  ls_hr_d = 4'd0;
               end else if (ls_hr_q == MAX_LS) begin
                  ls_hr_d = 4'd0;
                  ms_hr_d = ms_hr_q + 4'd1;
               end else begin
                  ls_hr_d = ls_hr_q + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sec_q        <= '0;
         ms_hr_q      <= '0;
         ls_hr_q      <= '0;
         ms_min_q     <= '0;
         ls_min_q     <= '0;
         one_minute_q <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         sec_q        <= sec_d;
         ms_hr_q      <= ms_hr_d;
         ls_hr_q      <= ls_hr_d;
         ms_min_q     <= ms_min_d;
         ls_min_q     <= ls_min_d;
         one_minute_q <= min_tc;
         load_error_q <= load_new_c && !load_ok;
      end
   end

   assign current_time_ms_hr  = ms_hr_q;
   assign current_time_ls_hr  = ls_hr_q;
   assign current_time_ms_min = ms_min_q;
   assign current_time_ls_min = ls_min_q;
   assign one_minute          = one_minute_q;
   assign load_error          = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_aclk_time_counter.sv
`default_nettype none
// ============================================================================
// tb_aclk_time_counter : directed + random stimulus against a minutes-of-day
//                        reference model.                        Rev 1.0
// ============================================================================
module tb_aclk_time_counter;

   localparam int CPS = 4;
   localparam int SPM = 3;

   logic       clock = 1'b0;
   logic       reset, fast_watch, load_new_c;
   logic [3:0] n_mh, n_lh, n_mm, n_lm;
   logic [3:0] c_mh, c_lh, c_mm, c_lm;
   logic       one_second, one_minute, load_error;

   int errors = 0;
   int checks = 0;

   // Reference state: time as minutes since midnight, plus cycle/second counts.
   int m_mins, m_pre, m_sec;
   bit m_os, m_om, m_err;

   always #5 clock = ~clock;

   aclk_time_counter #(.CLK_PER_SEC(CPS), .SEC_PER_MIN(SPM)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .fast_watch              (fast_watch),
      .load_new_c              (load_new_c),
      .new_current_time_ms_hr  (n_mh),
      .new_current_time_ls_hr  (n_lh),
      .new_current_time_ms_min (n_mm),
      .new_current_time_ls_min (n_lm),
      .current_time_ms_hr      (c_mh),
      .current_time_ls_hr      (c_lh),
      .current_time_ms_min     (c_mm),
      .current_time_ls_min     (c_lm),
      .one_second              (one_second),
      .one_minute              (one_minute),
      .load_error              (load_error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] dut_time();
      return {c_mh, c_lh, c_mm, c_lm};
   endfunction

   function automatic logic [15:0] exp_time();
      int h, m;
      h = m_mins / 60;
      m = m_mins % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   task automatic model_edge();
      int h, m;
      bit ok;
      m_os = 0; m_om = 0; m_err = 0;
      if (reset) begin
         m_mins = 0; m_pre = 0; m_sec = 0;
      end else if (load_new_c) begin
         h  = int'(n_mh) * 10 + int'(n_lh);
         m  = int'(n_mm) * 10 + int'(n_lm);
         ok = (n_mh <= 2) && (n_lh <= 9) && (n_mm <= 5) && (n_lm <= 9) && (h < 24);
         if (ok) begin
            m_mins = h * 60 + m; m_pre = 0; m_sec = 0;
         end else begin
            m_err = 1;
         end
      end else begin
         m_os  = (m_pre == CPS - 1);
         m_pre = (m_pre + 1) % CPS;
         if (fast_watch) begin
            m_sec = 0;
            m_om  = m_os;
         end else if (m_os) begin
            m_om  = (m_sec == SPM - 1);
            m_sec = (m_sec + 1) % SPM;
         end
         if (m_om) m_mins = (m_mins + 1) % 1440;
      end
   endtask

   task automatic step(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      check({tag, ".time"}, 32'(dut_time()), 32'(exp_time()));
      check({tag, ".one_second"}, 32'(one_second), 32'(m_os));
      check({tag, ".one_minute"}, 32'(one_minute), 32'(m_om));
      check({tag, ".load_error"}, 32'(load_error), 32'(m_err));
   endtask

   task automatic idle(input string tag, input int n);
      load_new_c = 0;
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic load(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
      load_new_c = 1; n_mh = a; n_lh = b; n_mm = c; n_lm = d;
      step(tag);
      load_new_c = 0;
   endtask

   initial begin
      reset = 1; fast_watch = 0; load_new_c = 0;
      n_mh = 0; n_lh = 0; n_mm = 0; n_lm = 0;
      #1;
      m_mins = 0; m_pre = 0; m_sec = 0;
      step("rst");
      step("rst");
      reset = 0;

      // 1: free run; first minute after 12 cycles
      idle("run", 11);
      step("run12");
      check("t1.minute12", 32'(one_minute), 32'd1);
      check("t1.time0001", 32'(dut_time()), 32'h0001);

      // 2: carry chain and midnight wrap
      load("ld0959", 4'd0, 4'd9, 4'd5, 4'd9); idle("c0959", 12);
      check("t2.1000", 32'(dut_time()), 32'h1000);
      load("ld1959", 4'd1, 4'd9, 4'd5, 4'd9); idle("c1959", 12);
      check("t2.2000", 32'(dut_time()), 32'h2000);
      load("ld2359", 4'd2, 4'd3, 4'd5, 4'd9); idle("c2359", 12);
      check("t2.0000", 32'(dut_time()), 32'h0000);
      check("t2.wrap_min", 32'(one_minute), 32'd1);

      // 3: rejected loads then a good one
      load("bad2400", 4'd2, 4'd4, 4'd0, 4'd0); idle("e1", 1);
      load("bad1960", 4'd1, 4'd9, 4'd6, 4'd0); idle("e2", 1);
      load("bad2A00", 4'd2, 4'hA, 4'd0, 4'd0); idle("e3", 1);
      load("bad3000", 4'd3, 4'd0, 4'd0, 4'd0);
      check("t3.err", 32'(load_error), 32'd1);
      load("ld1234", 4'd1, 4'd2, 4'd3, 4'd4);
      check("t3.1234", 32'(dut_time()), 32'h1234);
      check("t3.noerr", 32'(load_error), 32'd0);

      // 4: fast_watch from 00:00 for 8 seconds
      load("ld0000", 4'd0, 4'd0, 4'd0, 4'd0);
      fast_watch = 1; idle("fast", 32);
      check("t4.0008", 32'(dut_time()), 32'h0008);
      fast_watch = 0; idle("slow", 24);
      check("t4.0010", 32'(dut_time()), 32'h0010);

      // 5: load on the min_tc edge wins
      reset = 1; step("rst5"); reset = 0;
      idle("pre5", 11);
      load("ld0745", 4'd0, 4'd7, 4'd4, 4'd5);
      check("t5.nomin", 32'(one_minute), 32'd0);
      idle("post5", 12);
      check("t5.0746", 32'(dut_time()), 32'h0746);

      // 6: reset with a load pending
      load("ld0517", 4'd0, 4'd5, 4'd1, 4'd7); idle("mid6", 5);
      reset = 1; load_new_c = 1; n_mh = 4'd1; n_lh = 4'd1; n_mm = 4'd1; n_lm = 4'd1;
      step("rst6");
      check("t6.0000", 32'(dut_time()), 32'h0000);
      reset = 0; load_new_c = 0;
      idle("after6", 4);

      // random soak
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 299) == 0);
         load_new_c = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 99) == 0) fast_watch = ~fast_watch;
         n_mh = 4'($urandom_range(0, 3));
         n_lh = 4'($urandom_range(0, 10));
         n_mm = 4'($urandom_range(0, 6));
         n_lm = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 10));
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
